fifo_drain_arbiter: RTL and testbench

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/fifo_drain_arbiter.sv | 116 +++++++++++
 tb/tb_fifo_drain_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_FIFOS first-word-fall-through FIFOs round-robin, up to MAX_BURST reads per turn, into one output register.
// One cycle from read strobe to out_valid; a stalled output (out_valid && !out_ready) blocks all reads and holds data.
module fifo_drain_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4,
  parameter int MAX_BURST  = 4,
  localparam int SRC_W     = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_FIFOS-1:0]            fifo_rd_en,
  input  logic [NUM_FIFOS-1:0]            ch_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [SRC_W-1:0]                out_src,
  output logic                            busy
);

  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [SRC_W:0]  NF = (SRC_W + 1)'(NUM_FIFOS);
  localparam logic [BC_W-1:0] MB = BC_W'(MAX_BURST);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t                state_q;
  logic [SRC_W-1:0]      cur_q;
  logic [SRC_W-1:0]      last_grant_q;
  logic [BC_W-1:0]       burst_cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic [SRC_W-1:0]      out_src_q;

  logic [NUM_FIFOS-1:0]  eligible;
  logic                  load;
  logic [SRC_W-1:0]      base;
  logic [SRC_W:0]        cand;
  logic [SRC_W-1:0]      sel;
  logic                  sel_vld;
  logic                  sel_cont;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] dout_arr [NUM_FIFOS];

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_slice
    assign dout_arr[g] = fifo_dout[g*DATA_WIDTH +: DATA_WIDTH];
  end

  assign eligible = ~fifo_empty & ch_en;
  assign load     = !out_valid_q || out_ready;

  // Both IDLE and a burst switch scan base+1 .. base+NUM_FIFOS, so the base channel itself is tried last.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    sel_cont = 1'b0;
    cand     = '0;
    base     = (state_q == BURST) ? cur_q : last_grant_q;
    if (state_q == BURST && eligible[cur_q] && burst_cnt_q < MB) begin
      sel      = cur_q;
      sel_vld  = 1'b1;
      sel_cont = 1'b1;
    end else begin
      for (int k = 1; k <= NUM_FIFOS; k++) begin
        cand = {1'b0, base} + (SRC_W + 1)'(k);
        if (cand >= NF) cand = cand - NF;
        if (!sel_vld && eligible[cand[SRC_W-1:0]]) begin
          sel     = cand[SRC_W-1:0];
          sel_vld = 1'b1;
        end
      end
    end
  end

  assign rd_fire    = load && sel_vld;
  assign fifo_rd_en = (rst_n && rd_fire) ? (NUM_FIFOS'(1) << sel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_grant_q <= SRC_W'(NUM_FIFOS - 1);
      burst_cnt_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
    end else begin
      if (rd_fire) begin
        state_q     <= BURST;
        cur_q       <= sel;
        burst_cnt_q <= sel_cont ? burst_cnt_q + BC_W'(1) : BC_W'(1);
        out_valid_q <= 1'b1;
        out_data_q  <= dout_arr[sel];
        out_src_q   <= sel;
      end else begin
        // Nothing left to serve: remember where the round-robin stopped.
        if (state_q == BURST && load) begin
          state_q      <= IDLE;
          last_grant_q <= cur_q;
          burst_cnt_q  <= '0;
        end
        if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign busy      = (state_q == BURST);

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: queue-backed FIFOs, round-robin reference model and per-channel scoreboard.
module tb_fifo_drain_arbiter;

  localparam int N    = 4;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fifo_empty;
  logic [31:0] fifo_dout;
  logic [3:0]  fifo_rd_en;
  logic [3:0]  ch_en;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_src;
  logic        busy;

  fifo_drain_arbiter #(.DATA_WIDTH(8), .NUM_FIFOS(N), .MAX_BURST(MAXB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .ch_en      (ch_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  logic [7:0] q  [N][$];
  logic [7:0] sb [N][$];
  int checks = 0;
  int errors = 0;
  int accepted, pushed;

  // reference model state
  bit         m_active, m_vld;
  int         m_cur, m_last, m_run;
  logic [7:0] m_data;
  logic [1:0] m_src;

  // values observed at the last sampling point
  logic [3:0] obs_rd;
  logic       obs_vld, obs_busy;
  logic [7:0] obs_data;
  logic [1:0] obs_src;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_dout[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'($urandom);
    end
  endtask

  task automatic push(input int ch, input logic [7:0] w);
    q[ch].push_back(w);
    sb[ch].push_back(w);
    pushed++;
  endtask

  task automatic fill_all(input int n);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < n; j++) push(i, 8'($urandom));
    refresh();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      sb[i].delete();
    end
    m_active = 0; m_vld = 0; m_cur = 0; m_last = N - 1; m_run = 0;
    m_data = 8'h00; m_src = 2'd0;
    accepted = 0; pushed = 0;
    refresh();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One clock: sample and check at the falling edge, then pop FIFOs for the strobes seen.
  task automatic step();
    bit         load, cont;
    int         choice, base, c;
    logic [3:0] elig, exp_rd;
    logic [7:0] w;
    @(negedge clk);
    obs_rd = fifo_rd_en; obs_vld = out_valid; obs_busy = busy;
    obs_data = out_data; obs_src = out_src;
    for (int i = 0; i < N; i++) elig[i] = (q[i].size() != 0) && ch_en[i];
    load = !m_vld || out_ready;
    choice = -1; cont = 0;
    if (load) begin
      if (m_active && elig[m_cur] && m_run < MAXB) begin
        choice = m_cur; cont = 1;
      end else begin
        base = m_active ? m_cur : m_last;
        for (int k = 1; k <= N; k++) begin
          c = (base + k) % N;
          if (choice < 0 && elig[c]) choice = c;
        end
      end
    end
    exp_rd = (choice >= 0) ? 4'(1 << choice) : 4'b0000;
    checks++;
    if (obs_rd !== exp_rd) begin errors++; $display("FAIL rd_en: got %b expected %b at %0t", obs_rd, exp_rd, $time); end
    checks++;
    if (obs_vld !== m_vld) begin errors++; $display("FAIL out_valid: got %b expected %b at %0t", obs_vld, m_vld, $time); end
    checks++;
    if (obs_busy !== m_active) begin errors++; $display("FAIL busy: got %b expected %b at %0t", obs_busy, m_active, $time); end
    checks++;
    if (obs_data !== m_data) begin errors++; $display("FAIL out_data: got %h expected %h at %0t", obs_data, m_data, $time); end
    checks++;
    if (obs_src !== m_src) begin errors++; $display("FAIL out_src: got %0d expected %0d at %0t", obs_src, m_src, $time); end
    if (obs_vld === 1'b1 && out_ready) begin
      checks++;
      if (sb[int'(obs_src)].size() == 0) begin
        errors++; $display("FAIL scoreboard: word %h from ch %0d was never pushed", obs_data, obs_src);
      end else begin
        w = sb[int'(obs_src)].pop_front();
        accepted++;
        if (obs_data !== w) begin errors++; $display("FAIL scoreboard: ch %0d got %h expected %h", obs_src, obs_data, w); end
      end
    end
    if (choice >= 0) begin
      m_run = cont ? m_run + 1 : 1;
      m_cur = choice; m_active = 1;
      m_data = q[choice][0]; m_src = 2'(choice); m_vld = 1;
    end else begin
      if (load && m_active) begin m_last = m_cur; m_active = 0; end
      if (m_vld && out_ready) m_vld = 0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < N; i++)
      if (obs_rd[i] && q[i].size() != 0) void'(q[i].pop_front());
    refresh();
  endtask

  task automatic check_drained(input string name);
    int left = 0;
    for (int i = 0; i < N; i++) left += sb[i].size();
    checks++;
    if (left != 0 || accepted != pushed) begin
      errors++; $display("FAIL %s: accepted %0d of %0d pushed, %0d outstanding", name, accepted, pushed, left);
    end
  endtask

  task automatic test_reset();
    ch_en = 4'hF; out_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if ({obs_rd, obs_vld, obs_busy, obs_data, obs_src} !== 16'h0000) begin
        errors++; $display("FAIL reset_idle: rd=%b vld=%b busy=%b data=%h src=%0d, all must be 0", obs_rd, obs_vld, obs_busy, obs_data, obs_src);
      end
    end
  endtask

  task automatic test_single_channel();
    do_reset();
    for (int j = 0; j < 6; j++) push(2, 8'(8'h10 + j));
    refresh();
    for (int c = 0; c < 8; c++) begin
      step();
      checks++;
      if (obs_rd !== ((c < 6) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL single_rd c%0d: got %b", c, obs_rd);
      end
      if (c >= 1 && c <= 6) begin
        checks++;
        if (obs_vld !== 1'b1 || obs_data !== 8'(8'h10 + c - 1) || obs_src !== 2'd2) begin
          errors++; $display("FAIL single_out c%0d: vld=%b data=%h src=%0d expected 1 %h 2", c, obs_vld, obs_data, obs_src, 8'(8'h10 + c - 1));
        end
      end
    end
    checks++;
    if (obs_busy !== 1'b0 || obs_vld !== 1'b0) begin errors++; $display("FAIL single_end: busy=%b vld=%b expected 0 0", obs_busy, obs_vld); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_src;
    do_reset();
    fill_all(20);
    for (int c = 0; c <= 16; c++) begin
      step();
      if (c >= 1) begin
        exp_src = 2'(((c - 1) / MAXB) % N);
        checks++;
        if (obs_vld !== 1'b1 || obs_src !== exp_src) begin
          errors++; $display("FAIL rr_seq c%0d: vld=%b src=%0d expected 1 %0d", c, obs_vld, obs_src, exp_src);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_data;
    logic [1:0] held_src;
    do_reset();
    fill_all(6);
    for (int c = 0; c < 5; c++) step();
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (c == 0) begin held_data = obs_data; held_src = obs_src; end
      checks++;
      if (obs_rd !== 4'b0000 || obs_vld !== 1'b1 || obs_data !== held_data || obs_src !== held_src) begin
        errors++; $display("FAIL stall c%0d: rd=%b vld=%b data=%h src=%0d expected 0000 1 %h %0d", c, obs_rd, obs_vld, obs_data, obs_src, held_data, held_src);
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && accepted < pushed; c++) step();
    check_drained("stall_drain");
  endtask

  task automatic test_ch_en_switch();
    do_reset();
    for (int j = 0; j < 6; j++) begin push(1, 8'($urandom)); push(2, 8'($urandom)); end
    refresh();
    for (int c = 0; c < 2; c++) begin
      step();
      checks++;
      if (obs_rd !== 4'b0010) begin errors++; $display("FAIL chen_pre c%0d: rd=%b expected 0010", c, obs_rd); end
    end
    ch_en = 4'b1101;
    step();
    checks++;
    if (obs_rd !== 4'b0100) begin errors++; $display("FAIL chen_switch: rd=%b expected 0100", obs_rd); end
    ch_en = 4'hF;
  endtask

  task automatic test_random();
    int ch;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if (c % 13 == 0) ch_en = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        ch = $urandom_range(0, N - 1);
        if (q[ch].size() < 6) push(ch, 8'($urandom));
      end
      refresh();
      step();
    end
    ch_en = 4'hF; out_ready = 1'b1;
    for (int c = 0; c < 200 && accepted < pushed; c++) step();
    check_drained("random_drain");
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    do_reset();
    fill_all(10);
    while (!(m_active && m_cur == 3 && m_run >= 2) && n < 50) begin step(); n++; end
    checks++;
    if (n >= 50) begin errors++; $display("FAIL midrst_reach: no burst on channel 3 within 50 cycles"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_rd_en !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_immediate: vld=%b rd=%b busy=%b expected 0 0000 0", out_valid, fifo_rd_en, busy);
    end
    do_reset();
    fill_all(4);
    step();
    checks++;
    if (obs_rd !== 4'b0001) begin errors++; $display("FAIL midrst_first_rd: rd=%b expected 0001", obs_rd); end
    step();
    checks++;
    if (obs_vld !== 1'b1 || obs_src !== 2'd0) begin errors++; $display("FAIL midrst_first_src: vld=%b src=%0d expected 1 0", obs_vld, obs_src); end
  endtask

  initial begin
    rst_n = 1'b0; ch_en = 4'hF; out_ready = 1'b1;
    refresh();
    test_reset();
    test_single_channel();
    test_round_robin();
    test_backpressure();
    test_ch_en_switch();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
